// File: rtl/datamem_pkg.sv
// Shared types and helpers for the pipelined data memory.
// Response entries are sized for the widest data path, and the top truncates them.
package datamem_pkg;

  localparam int MAX_READ_LAT   = 4;
  localparam int MAX_DATA_BYTES = 8;

  typedef struct packed {
    logic [8*MAX_DATA_BYTES-1:0] rdata;
    logic                        err;
    logic                        write;
  } mem_resp_t;

  function automatic logic is_pow2(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic size_legal(input logic [3:0] size, input int data_bytes);
    return is_pow2(size) && (int'(size) <= data_bytes);
  endfunction

endpackage

// File: rtl/datamem_pipelined_fifo.sv
// Synchronous response FIFO holding mem_resp_t entries between pipeline exit and the response port.
// Entry storage carries no reset; only the pointers and the count are cleared.
module mem_resp_fifo
  import datamem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  mem_resp_t push_data,
  input  logic      pop,
  output mem_resp_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  mem_resp_t        entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/datamem_pipelined.sv
// Pipelined byte-addressed data memory with a valid/ready request port and in-order responses.
// Accesses are checked for legality at accept, and illegal ones come back as error responses.
module datamem_pipelined
  import datamem_pkg::*;
#(
  parameter int MEM_BYTES  = 128,
  parameter int DATA_BYTES = 8,
  parameter int ADDR_W     = 64,
  parameter int READ_LAT   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [3:0]              req_size,
  input  logic                    req_signed,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*DATA_BYTES-1:0] resp_rdata,
  output logic                    resp_err,
  output logic                    resp_write
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int RW    = 8 * MAX_DATA_BYTES;
  localparam int CNT_W = $clog2(MAX_READ_LAT + 1);

  logic [7:0]        mem [MEM_BYTES];
  logic [AW-1:0]     base;
  logic [ADDR_W:0]   end_addr;
  logic [ADDR_W-1:0] align_mask;
  logic              req_legal;
  logic              accept;
  logic              pop;

  logic [RW-1:0]     raw;
  logic [RW-1:0]     ext;
  logic              sign_bit;
  logic [DW-1:0]     load_data;
  mem_resp_t         entry;

  logic [READ_LAT-1:0] stage_valid;
  mem_resp_t           stage_data [READ_LAT];
  logic [CNT_W-1:0]    outstanding;

  logic      fifo_push;
  mem_resp_t fifo_push_data;
  mem_resp_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;

  // The end address is one bit wider than the request so huge addresses cannot wrap into range.
  assign base       = req_addr[AW-1:0];
  assign end_addr   = {1'b0, req_addr} + (ADDR_W+1)'(req_size);
  assign align_mask = ADDR_W'(req_size) - ADDR_W'(1);
  assign req_legal  = size_legal(req_size, DATA_BYTES)
                   && ((req_addr & align_mask) == '0)
                   && (end_addr <= (ADDR_W+1)'(MEM_BYTES));

  assign resp_valid = !reset && !fifo_empty;
  assign pop        = resp_valid && resp_ready;
  assign req_ready  = !reset && ((outstanding < CNT_W'(READ_LAT)) || pop);
  assign accept     = req_valid && req_ready;

  always_comb begin
    raw      = '0;
    sign_bit = 1'b0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (4'(i) < req_size) raw[8*i +: 8] = mem[base + AW'(i)];
    end
    case (req_size)
      4'd1:    sign_bit = raw[7];
      4'd2:    sign_bit = raw[15];
      4'd4:    sign_bit = raw[31];
      4'd8:    sign_bit = raw[63];
      default: sign_bit = 1'b0;
    endcase
    ext = raw;
    if (req_signed && sign_bit) begin
      for (int i = 0; i < MAX_DATA_BYTES; i++) begin
        if (4'(i) >= req_size) ext[8*i +: 8] = 8'hFF;
      end
    end
    load_data = ext[DW-1:0];
  end

  always_comb begin
    entry       = '0;
    entry.err   = !req_legal;
    entry.write = req_write;
    if (req_legal && !req_write) entry.rdata = RW'(load_data);
  end

  // Storage is never reset, so committed stores survive a reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && req_legal) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (4'(i) < req_size) mem[base + AW'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= accept;
      for (int k = 1; k < READ_LAT; k++) stage_valid[k] <= stage_valid[k-1];
    end
  end

  always_ff @(posedge clk) begin
    stage_data[0] <= entry;
    for (int k = 1; k < READ_LAT; k++) stage_data[k] <= stage_data[k-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign fifo_push      = stage_valid[READ_LAT-1];
  assign fifo_push_data = stage_data[READ_LAT-1];

  mem_resp_fifo #(
    .DEPTH (READ_LAT)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Credit tracking bounds the FIFO occupancy, so a push into a full FIFO without a pop is a bug.
  assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full && !pop));

  assign resp_rdata = resp_valid ? fifo_head.rdata[DW-1:0] : '0;
  assign resp_err   = resp_valid && fifo_head.err;
  assign resp_write = resp_valid && fifo_head.write;

endmodule
